// File: rtl/peripheral_msi_mux_ctrl_wb_if.sv
// Wishbone bundle between one master and NUM_SLAVES slaves.
// The slave modport is the mux view; the master modport is the bench/system view.
interface peripheral_msi_mux_ctrl_wb_if #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int NUM_SLAVES = 4
);

    // Upstream master side
    logic [AW-1:0]                       wbm_adr_i;
    logic [DW-1:0]                       wbm_dat_i;
    logic [DW/8-1:0]                     wbm_sel_i;
    logic                                wbm_we_i;
    logic                                wbm_cyc_i;
    logic                                wbm_stb_i;
    logic [2:0]                          wbm_cti_i;
    logic [1:0]                          wbm_bte_i;
    logic [DW-1:0]                       wbm_dat_o;
    logic                                wbm_ack_o;
    logic                                wbm_err_o;
    logic                                wbm_rty_o;

    // Downstream slave side
    logic [NUM_SLAVES-1:0][AW-1:0]       wbs_adr_o;
    logic [NUM_SLAVES-1:0][DW-1:0]       wbs_dat_o;
    logic [NUM_SLAVES-1:0][DW/8-1:0]     wbs_sel_o;
    logic [NUM_SLAVES-1:0]               wbs_we_o;
    logic [NUM_SLAVES-1:0]               wbs_cyc_o;
    logic [NUM_SLAVES-1:0]               wbs_stb_o;
    logic [NUM_SLAVES-1:0][2:0]          wbs_cti_o;
    logic [NUM_SLAVES-1:0][1:0]          wbs_bte_o;
    logic [NUM_SLAVES-1:0][DW-1:0]       wbs_dat_i;
    logic [NUM_SLAVES-1:0]               wbs_ack_i;
    logic [NUM_SLAVES-1:0]               wbs_err_i;
    logic [NUM_SLAVES-1:0]               wbs_rty_i;

    modport slave (
        input  wbm_adr_i,
        input  wbm_dat_i,
        input  wbm_sel_i,
        input  wbm_we_i,
        input  wbm_cyc_i,
        input  wbm_stb_i,
        input  wbm_cti_i,
        input  wbm_bte_i,
        output wbm_dat_o,
        output wbm_ack_o,
        output wbm_err_o,
        output wbm_rty_o,
        output wbs_adr_o,
        output wbs_dat_o,
        output wbs_sel_o,
        output wbs_we_o,
        output wbs_cyc_o,
        output wbs_stb_o,
        output wbs_cti_o,
        output wbs_bte_o,
        input  wbs_dat_i,
        input  wbs_ack_i,
        input  wbs_err_i,
        input  wbs_rty_i
    );

    modport master (
        output wbm_adr_i,
        output wbm_dat_i,
        output wbm_sel_i,
        output wbm_we_i,
        output wbm_cyc_i,
        output wbm_stb_i,
        output wbm_cti_i,
        output wbm_bte_i,
        input  wbm_dat_o,
        input  wbm_ack_o,
        input  wbm_err_o,
        input  wbm_rty_o,
        input  wbs_adr_o,
        input  wbs_dat_o,
        input  wbs_sel_o,
        input  wbs_we_o,
        input  wbs_cyc_o,
        input  wbs_stb_o,
        input  wbs_cti_o,
        input  wbs_bte_o,
        output wbs_dat_i,
        output wbs_ack_i,
        output wbs_err_i,
        output wbs_rty_i
    );

endinterface

// File: rtl/peripheral_msi_mux_ctrl_wb.sv
// Wishbone 1-to-N address-decoding mux with burst lock and decode-error reply.
// Optional per-beat stall watchdog: PERIPHERAL_MSI_MUX_CTRL_WB_TIMEOUT_EN.
module peripheral_msi_mux_ctrl_wb #(
    parameter int                         DW         = 32,
    parameter int                         AW         = 32,
    parameter int                         NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*AW-1:0]   MATCH_ADDR = '0,
    parameter logic [NUM_SLAVES*AW-1:0]   MATCH_MASK = '0,
    parameter int                         TIMEOUT    = 255
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    peripheral_msi_mux_ctrl_wb_if.slave   bus,
    output logic                          decerr_o,
    output logic                          timeout_o
);

    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DECERR,
        HOLD
    } state_e;

    state_e          state_q;
    logic [SW-1:0]   sel_q;

    logic            hit;
    logic [SW-1:0]   hit_idx;

    logic            active;
    logic [DW-1:0]   sel_dat;
    logic            sel_ack;
    logic            sel_err;
    logic            sel_rty;
    logic            sel_resp;
    logic            abort;

    // Address decode; scanning downwards lets the lowest index win
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.wbm_adr_i & MATCH_MASK[i*AW +: AW])
                == MATCH_ADDR[i*AW +: AW]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    assign active   = (state_q == ACTIVE);
    assign sel_dat  = bus.wbs_dat_i[sel_q];
    assign sel_ack  = bus.wbs_ack_i[sel_q];
    assign sel_err  = bus.wbs_err_i[sel_q];
    assign sel_rty  = bus.wbs_rty_i[sel_q];
    assign sel_resp = sel_ack | sel_err | sel_rty;

`ifdef PERIPHERAL_MSI_MUX_CTRL_WB_TIMEOUT_EN
    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  MAXC = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stall;

    // A beat aborts when this stalled cycle would bring the count to TIMEOUT
    assign stall     = active & bus.wbm_stb_i & ~sel_resp;
    assign abort     = stall & (cnt_q == LAST);
    assign timeout_o = abort;

    // Stall counter: zero outside ACTIVE, cleared by any response, saturating
    always_comb begin
        cnt_d = cnt_q;
        if (!active) begin
            cnt_d = '0;
        end else if (sel_resp) begin
            cnt_d = '0;
        end else if (bus.wbm_stb_i && (cnt_q != MAXC)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
    assign abort          = 1'b0;
    assign timeout_o      = 1'b0;
`endif

    // Control FSM: decode on request, lock the slave until cyc drops
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
                        if (hit) begin
                            sel_q   <= hit_idx;
                            state_q <= ACTIVE;
                        end else begin
                            state_q <= DECERR;
                        end
                    end
                end
                ACTIVE: begin
                    if (!bus.wbm_cyc_i) begin
                        state_q <= IDLE;
                    end else if (abort) begin
                        state_q <= HOLD;
                    end
                end
                DECERR: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (!bus.wbm_cyc_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Request fan-out: payload to every slave, cyc/stb only to the locked one
    always_comb begin
        bus.wbs_cyc_o = '0;
        bus.wbs_stb_o = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            bus.wbs_adr_o[i] = bus.wbm_adr_i;
            bus.wbs_dat_o[i] = bus.wbm_dat_i;
            bus.wbs_sel_o[i] = bus.wbm_sel_i;
            bus.wbs_we_o[i]  = bus.wbm_we_i;
            bus.wbs_cti_o[i] = bus.wbm_cti_i;
            bus.wbs_bte_o[i] = bus.wbm_bte_i;
        end
        if (active && !abort) begin
            bus.wbs_cyc_o[sel_q] = bus.wbm_cyc_i;
            bus.wbs_stb_o[sel_q] = bus.wbm_stb_i;
        end
    end

    // Response path back to the master
    always_comb begin
        bus.wbm_dat_o = active ? sel_dat : '0;
        bus.wbm_ack_o = active & sel_ack;
        bus.wbm_rty_o = active & sel_rty;
        bus.wbm_err_o = (active & sel_err)
                      | (state_q == DECERR)
                      | abort;
    end

    assign decerr_o = (state_q == DECERR);

endmodule

// File: tb/tb_peripheral_msi_mux_ctrl_wb.sv
// Scoreboard bench for peripheral_msi_mux_ctrl_wb.
// Slaves are modelled with a programmable number of stall cycles per beat.
module tb_peripheral_msi_mux_ctrl_wb;

    localparam int TMO = 8;
    localparam int K_ACK = 0;
    localparam int K_DEC = 1;
    localparam int K_TMO = 2;

`ifdef PERIPHERAL_MSI_MUX_CTRL_WB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        int          kind;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    logic decerr;
    logic tmo;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    logic [3:0] exp_mask = 4'b0;
    int         lat[4];
    int         wcnt[4];
    bit         seen[4];
    logic [31:0] sadr[4];
    exp_t       q[$];

    peripheral_msi_mux_ctrl_wb_if #(
        .DW(32), .AW(32), .NUM_SLAVES(4)
    ) bus ();

    peripheral_msi_mux_ctrl_wb #(
        .DW(32),
        .AW(32),
        .NUM_SLAVES(4),
        .MATCH_ADDR({32'h4000_0000, 32'h2000_0000,
                     32'h1000_0000, 32'h2000_0000}),
        .MATCH_MASK({32'hC000_0000, 32'hE000_0000,
                     32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT(TMO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus),
        .decerr_o (decerr),
        .timeout_o(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Region map of the four slaves, listed in priority order
    function automatic int ref_decode(input logic [31:0] a);
        if (a >= 32'h2000_0000 && a <= 32'h2FFF_FFFF) return 0;
        if (a >= 32'h1000_0000 && a <= 32'h1FFF_FFFF) return 1;
        if (a >= 32'h2000_0000 && a <= 32'h3FFF_FFFF) return 2;
        if (a >= 32'h4000_0000 && a <= 32'h7FFF_FFFF) return 3;
        return -1;
    endfunction

    function automatic logic [31:0] rdata(input int i, input logic [31:0] a);
        return a ^ {4'(i + 1), 28'h0} ^ 32'h0000_C3C3;
    endfunction

    task automatic check(input bit ok, input string nm,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Slave models: registered ack after lat[i] stalled cycles
    initial begin
        bus.wbs_dat_i = '0;
        bus.wbs_ack_i = '0;
        bus.wbs_err_i = '0;
        bus.wbs_rty_i = '0;
        for (int i = 0; i < 4; i++) begin
            wcnt[i] = 0;
            lat[i]  = 1;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                seen[i] = bus.wbs_cyc_o[i] && bus.wbs_stb_o[i];
                sadr[i] = bus.wbs_adr_o[i];
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (seen[i] && !bus.wbs_ack_i[i]) wcnt[i]++;
                else wcnt[i] = 0;
                bus.wbs_ack_i[i] = (wcnt[i] != 0) && (wcnt[i] >= lat[i]);
                bus.wbs_dat_i[i] = rdata(i, sadr[i]);
            end
        end
    end

    // Monitor: every cycle check routing, pop scoreboard on responses
    initial begin
        exp_t e;
        logic resp;
        bit   bc;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                resp = bus.wbm_ack_o | bus.wbm_err_o | bus.wbm_rty_o;
                bc = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    if (bus.wbs_adr_o[k] !== bus.wbm_adr_i ||
                        bus.wbs_dat_o[k] !== bus.wbm_dat_i ||
                        bus.wbs_we_o[k]  !== bus.wbm_we_i  ||
                        bus.wbs_cti_o[k] !== bus.wbm_cti_i)
                        bc = 1'b0;
                end
                check(bc, "bcast", 64'(bus.wbs_adr_o[0]),
                      64'(bus.wbm_adr_i));
                check(((bus.wbs_cyc_o | bus.wbs_stb_o) & ~exp_mask) == 4'b0,
                      "cyc_route", 64'(bus.wbs_cyc_o), 64'(exp_mask));
                if (!resp) begin
                    check(!decerr && !tmo, "quiet_pulse",
                          64'({decerr, tmo}), 64'(0));
                end else if (q.size() == 0) begin
                    check(1'b0, "unexp_resp",
                          64'({bus.wbm_ack_o, bus.wbm_err_o}), 64'(0));
                end else begin
                    e = q.pop_front();
                    if (e.kind == K_ACK) begin
                        check({bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o,
                               decerr, tmo, bus.wbm_dat_o}
                              == {5'b10000, e.data}, "ack_resp",
                              64'({bus.wbm_ack_o, bus.wbm_err_o,
                                   bus.wbm_rty_o, decerr, tmo,
                                   bus.wbm_dat_o}),
                              64'({5'b10000, e.data}));
                    end else if (e.kind == K_DEC) begin
                        check({bus.wbm_err_o, decerr, tmo, bus.wbm_ack_o,
                               bus.wbm_dat_o, bus.wbs_cyc_o}
                              == {4'b1100, 32'h0, 4'h0}, "decerr_resp",
                              64'({bus.wbm_err_o, decerr, tmo,
                                   bus.wbm_ack_o, bus.wbm_dat_o,
                                   bus.wbs_cyc_o}),
                              64'({4'b1100, 32'h0, 4'h0}));
                    end else begin
                        check({bus.wbm_err_o, tmo, decerr, bus.wbm_ack_o,
                               bus.wbs_cyc_o} == 8'b1100_0000, "tmo_resp",
                              64'({bus.wbm_err_o, tmo, decerr,
                                   bus.wbm_ack_o, bus.wbs_cyc_o}),
                              64'(8'b1100_0000));
                    end
                end
            end
        end
    end

    task automatic idle_master();
        bus.wbm_cyc_i = 1'b0;
        bus.wbm_stb_i = 1'b0;
        bus.wbm_we_i  = 1'b0;
        bus.wbm_cti_i = 3'b000;
        bus.wbm_bte_i = 2'b00;
    endtask

    // One master cycle of nb incrementing beats starting at a0
    task automatic do_txn(input logic [31:0] a0, input int nb, input logic we);
        int          s;
        int          n;
        bit          done;
        bit          got_err;
        logic [31:0] a;
        exp_t        e;
        s = ref_decode(a0);
        exp_mask = (s < 0) ? 4'b0 : 4'(1 << s);
        for (int b = 0; b < nb; b++) begin
            a = a0 + 32'(4 * b);
            if (s < 0) e.kind = K_DEC;
            else if (TO_EN && lat[s] >= TMO) e.kind = K_TMO;
            else e.kind = K_ACK;
            e.data = (s < 0) ? 32'h0 : rdata(s, a);
            q.push_back(e);
            bus.wbm_cyc_i = 1'b1;
            bus.wbm_stb_i = 1'b1;
            bus.wbm_adr_i = a;
            bus.wbm_we_i  = we;
            bus.wbm_dat_i = $urandom();
            bus.wbm_sel_i = 4'hF;
            bus.wbm_bte_i = 2'b00;
            bus.wbm_cti_i = (nb == 1) ? 3'b000 :
                            (b == nb - 1) ? 3'b111 : 3'b010;
            n = 0;
            done = 1'b0;
            got_err = 1'b0;
            while (!done) begin
                @(negedge clk);
                #2;
                if (b == 0 && n == 0)
                    check(bus.wbs_cyc_o == 4'b0, "dec_lat0",
                          64'(bus.wbs_cyc_o), 64'(0));
                if (b == 0 && n == 1 && s >= 0)
                    check(bus.wbs_cyc_o == exp_mask, "dec_lat1",
                          64'(bus.wbs_cyc_o), 64'(exp_mask));
                if (bus.wbm_ack_o || bus.wbm_err_o || bus.wbm_rty_o) begin
                    done = 1'b1;
                    got_err = bus.wbm_err_o;
                    if (e.kind == K_TMO)
                        check(n == TMO, "tmo_cycle", 64'(n), 64'(TMO));
                    if (e.kind == K_DEC)
                        check(n == 1, "dec_cycle", 64'(n), 64'(1));
                end else if (n >= 400) begin
                    check(1'b0, "beat_wait", 64'(n), 64'(400));
                    done = 1'b1;
                    got_err = 1'b1;
                end
                n++;
                @(posedge clk);
                #1;
            end
            if (got_err) begin
                @(negedge clk);
                #2;
                check(!bus.wbm_err_o && bus.wbs_cyc_o == 4'b0, "err_1cyc",
                      64'({bus.wbm_err_o, bus.wbs_cyc_o}), 64'(0));
                @(posedge clk);
                #1;
                break;
            end
        end
        idle_master();
        @(negedge clk);
        #2;
        check(bus.wbs_cyc_o == 4'b0, "cyc_drop", 64'(bus.wbs_cyc_o), 64'(0));
        @(posedge clk);
        #1;
        exp_mask = 4'b0;
    endtask

    // Without the watchdog a stalled slave keeps cyc for as long as asked
    task automatic hold_test();
        int bad;
        bad = 0;
        lat[1] = 100000;
        exp_mask = 4'b0010;
        bus.wbm_adr_i = 32'h1000_0010;
        bus.wbm_cti_i = 3'b000;
        bus.wbm_cyc_i = 1'b1;
        bus.wbm_stb_i = 1'b1;
        for (int n = 0; n <= 100; n++) begin
            @(negedge clk);
            #2;
            if (n == 0 && bus.wbs_cyc_o != 4'b0) bad++;
            if (n >= 1 && (bus.wbs_cyc_o != 4'b0010 || bus.wbm_err_o)) bad++;
            @(posedge clk);
            #1;
        end
        check(bad == 0, "hold100", 64'(bad), 64'(0));
        idle_master();
        @(negedge clk);
        #2;
        check(bus.wbs_cyc_o == 4'b0, "hold_drop", 64'(bus.wbs_cyc_o), 64'(0));
        @(posedge clk);
        #1;
        exp_mask = 4'b0;
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbm_ack_o,
                    bus.wbm_err_o, bus.wbm_rty_o, decerr, tmo,
                    bus.wbm_dat_o});
    endfunction

    // Reset while a beat is stalled in ACTIVE
    task automatic reset_test();
        lat[2] = 1000;
        exp_mask = 4'b0100;
        bus.wbm_adr_i = 32'h3000_0000;
        bus.wbm_cti_i = 3'b000;
        bus.wbm_cyc_i = 1'b1;
        bus.wbm_stb_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        #2;
        check(outs_vec() == 64'(0), "rst_mid", outs_vec(), 64'(0));
        idle_master();
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_mask = 4'b0;
        lat[2] = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit actual=expired required=done");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        idle_master();
        bus.wbm_adr_i = '0;
        bus.wbm_dat_i = '0;
        bus.wbm_sel_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check(outs_vec() == 64'(0), "rst_state", outs_vec(), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        lat[1] = 2;
        do_txn(32'h1000_0004, 1, 1'b0);
        do_txn(32'hE000_0000, 1, 1'b0);
        lat[0] = 1;
        do_txn(32'h2000_0100, 1, 1'b1);
        lat[0] = TMO - 1;
        do_txn(32'h2FFF_FFF8, 4, 1'b0);

`ifdef PERIPHERAL_MSI_MUX_CTRL_WB_TIMEOUT_EN
        lat[1] = 1000;
        do_txn(32'h1000_0010, 1, 1'b0);
`else
        hold_test();
`endif

        reset_test();
        lat[2] = 1;
        do_txn(32'h3000_0040, 1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) lat[i] = $urandom_range(1, 10);
            case ($urandom_range(0, 4))
                0: a = {4'h1, 28'($urandom())};
                1: a = {4'h2, 28'($urandom())};
                2: a = {4'h3, 28'($urandom())};
                3: a = {2'b01, 30'($urandom())};
                default: a = $urandom();
            endcase
            a = a & 32'hFFFF_FFFC;
            do_txn(a, $urandom_range(1, 4), 1'($urandom()));
        end

        repeat (4) @(posedge clk);
        check(q.size() == 0, "sb_drain", 64'(q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/peripheral_msi_mux_ctrl_wb.md
PERIPHERAL_MSI_MUX_CTRL_WB -- requirements
Module: peripheral_msi_mux_ctrl_wb

Interface
REQ-001 SHALL have parameters: DW 32 data width; AW 32 address width; NUM_SLAVES 4 slave count (>=1); MATCH_ADDR 0 packed NUM_SLAVES*AW per-slave base; MATCH_MASK 0 packed NUM_SLAVES*AW per-slave mask; TIMEOUT 255 max stalled cycles per beat (>=1).
REQ-002 SHALL use one clock and a synchronous active-high reset: wb_clk_i in 1 clock; wb_rst_i in 1 reset.
REQ-003 SHALL have master ports: wbm_adr_i in AW; wbm_dat_i in DW; wbm_sel_i in DW/8; wbm_we_i, wbm_cyc_i, wbm_stb_i in 1; wbm_cti_i in 3; wbm_bte_i in 2; wbm_dat_o out DW; wbm_ack_o, wbm_err_o, wbm_rty_o out 1.
REQ-004 SHALL have slave ports, each packed [NUM_SLAVES-1:0][width]: wbs_adr_o out AW; wbs_dat_o out DW; wbs_sel_o out DW/8; wbs_we_o, wbs_cyc_o, wbs_stb_o out 1; wbs_cti_o out 3; wbs_bte_o out 2; wbs_dat_i in DW; wbs_ack_i, wbs_err_i, wbs_rty_i in 1.
REQ-005 SHALL have status outputs: decerr_o out 1, one-cycle pulse on decode error; timeout_o out 1, one-cycle pulse on watchdog abort.

Function
REQ-006 SHALL compute match[i] = (wbm_adr_i & MATCH_MASK[i]) == MATCH_ADDR[i]; on multiple matches the lowest index SHALL win.
REQ-007 SHALL implement FSM states IDLE, ACTIVE, DECERR, HOLD.
REQ-008 IDLE: on wbm_cyc_i & wbm_stb_i, any match -> latch winning index into sel, go ACTIVE; no match -> go DECERR; otherwise stay.
REQ-009 Decode latency SHALL be one cycle: slave sees cyc/stb the cycle after master request in IDLE.
REQ-010 ACTIVE: wbs_cyc_o[sel] = wbm_cyc_i, wbs_stb_o[sel] = wbm_stb_i; all other slave cyc/stb SHALL be 0; sel SHALL NOT change until IDLE re-entered (burst lock).
REQ-011 ACTIVE: wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o SHALL be combinational copies of slave sel's inputs.
REQ-012 ACTIVE with wbm_cyc_i low -> IDLE next cycle; slave cyc drops the same cycle master cyc drops.
REQ-013 DECERR: wbm_err_o = 1 and decerr_o = 1 for exactly one cycle, then HOLD.
REQ-014 HOLD: all slave cyc/stb 0, master ack/err/rty 0; wbm_cyc_i low -> IDLE.
REQ-015 Outside ACTIVE, wbm_dat_o SHALL be 0 and wbm_ack_o/wbm_rty_o 0; wbm_err_o 0 except REQ-013/REQ-018.
REQ-016 adr/dat/sel/we/cti/bte SHALL be broadcast unmodified to all slaves.
REQ-017 Watchdog counter, width $clog2(TIMEOUT+1), SHALL clear on entering ACTIVE and on any ack/err/rty from slave sel, and increment each ACTIVE cycle with wbm_stb_i high and no response.
REQ-018 Counter reaching TIMEOUT with no response that cycle: wbm_err_o = 1 and timeout_o = 1 that cycle, slave cyc/stb forced 0, next state HOLD.
REQ-019 Slave response in the same cycle counter hits TIMEOUT: response SHALL win, no abort, counter clears.
REQ-020 Counter SHALL saturate, never wrap.

Reset
REQ-021 wb_rst_i high at a clock edge: state IDLE, sel 0, counter 0; next cycle all wbs_cyc_o/wbs_stb_o, wbm_ack_o/err/rty, wbm_dat_o, decerr_o, timeout_o SHALL be 0, including mid-transaction.

Configuration
REQ-022 Macro PERIPHERAL_MSI_MUX_CTRL_WB_TIMEOUT_EN: defined -> watchdog per REQ-017..REQ-020; undefined -> no counter, ACTIVE lasts until master drops cyc, timeout_o tied 0, TIMEOUT ignored.

Verification
REQ-023 NUM_SLAVES=4, slave1 at 0x1000_0000 mask 0xF000_0000, read 0x1000_0004 -> wbs_cyc_o=4'b0010 one cycle after request, ack and data of slave1 returned.
REQ-024 Address 0xE000_0000 matching no slave -> wbm_err_o and decerr_o high exactly one cycle, no wbs_cyc_o asserted, IDLE after cyc drops.
REQ-025 Overlapping slaves 0 and 2 both match -> only slave 0 gets cyc.
REQ-026 TIMEOUT=8, slave never acks (macro defined) -> wbm_err_o/timeout_o pulse on 8th stalled cycle, slave cyc drops; macro undefined -> cyc held 100 cycles, no err.
REQ-027 4-beat burst (cti=3'b010) with address crossing into slave 2's range mid-burst -> all beats stay on latched slave; ack on cycle TIMEOUT -> no abort.
REQ-028 wb_rst_i asserted during ACTIVE -> all slave cyc and master responses 0 next cycle, new request decodes normally after release.
